// File: rtl/ibex_mem_arbiter.sv
// Two-port (fetch/LSU) arbiter onto a single-port RAM, with an in-flight
// response tracker that routes rvalid/rdata back to the issuing port.
module ibex_mem_arbiter #(
  parameter int          MemDepth   = 16384,
  parameter int          MemAw      = $clog2(MemDepth),
  parameter logic [31:0] BaseAddr   = 32'h0000_0000,
  parameter int          MemLatency = 1,
  parameter int          DataPrio   = 0,
  parameter int          CntWidth   = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                instr_req_i,
  output logic                instr_gnt_o,
  output logic                instr_rvalid_o,
  input  logic [31:0]         instr_addr_i,
  output logic [31:0]         instr_rdata_o,
  output logic                instr_err_o,
  input  logic                data_req_i,
  output logic                data_gnt_o,
  output logic                data_rvalid_o,
  input  logic                data_we_i,
  input  logic [3:0]          data_be_i,
  input  logic [31:0]         data_addr_i,
  input  logic [31:0]         data_wdata_i,
  output logic [31:0]         data_rdata_o,
  output logic                data_err_o,
  output logic                mem_req_o,
  output logic                mem_write_o,
  output logic [3:0]          mem_be_o,
  output logic [MemAw-1:0]    mem_addr_o,
  output logic [31:0]         mem_wdata_o,
  input  logic                mem_rvalid_i,
  input  logic [31:0]         mem_rdata_i,
  output logic [CntWidth-1:0] conflict_cnt_o,
  output logic                protocol_err_o
);

  // owner: 1 = data port, 0 = instr port
  typedef struct packed {
    logic vld;
    logic owner;
    logic err;
  } trk_t;

  localparam logic [32:0] Span = 33'(MemDepth) * 33'd4;

  trk_t [MemLatency:1] trk_pipe;
  trk_t                push, head;
  logic                last_data;
  logic                both, win_data, grant, in_range, head_vld;
  logic [31:0]         win_addr, off, rsp_data;

  always_comb begin
    both = instr_req_i & data_req_i;
    if (DataPrio != 0) win_data = data_req_i;
    else               win_data = data_req_i & (~instr_req_i | ~last_data);
    grant       = (instr_req_i | data_req_i) & ~rst_i;
    instr_gnt_o = grant & ~win_data;
    data_gnt_o  = grant & win_data;

    win_addr = win_data ? data_addr_i : instr_addr_i;
    off      = win_addr - BaseAddr;
    in_range = (win_addr >= BaseAddr) && ({1'b0, off} < Span);

    mem_req_o   = grant & in_range;
    mem_write_o = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    if (mem_req_o) begin
      mem_addr_o = off[MemAw+1:2];
      if (win_data) begin
        mem_write_o = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_be_o = 4'hF;
      end
    end

    push = '{vld: grant, owner: win_data, err: grant & ~in_range};
  end

  // Head of the tracker lines up with mem_rvalid_i for the same access.
  always_comb begin
    head           = trk_pipe[MemLatency];
    head_vld       = head.vld & ~rst_i;
    rsp_data       = head.err ? 32'h0 : mem_rdata_i;
    instr_rvalid_o = head_vld & ~head.owner;
    data_rvalid_o  = head_vld & head.owner;
    instr_err_o    = instr_rvalid_o & head.err;
    data_err_o     = data_rvalid_o & head.err;
    instr_rdata_o  = instr_rvalid_o ? rsp_data : 32'h0;
    data_rdata_o   = data_rvalid_o ? rsp_data : 32'h0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trk_pipe       <= '0;
      last_data      <= 1'b1;
      conflict_cnt_o <= '0;
      protocol_err_o <= 1'b0;
    end else begin
      trk_pipe[1] <= push;
      for (int i = 2; i <= MemLatency; i++) trk_pipe[i] <= trk_pipe[i-1];
      if (both) last_data <= win_data;
      if (both && !(&conflict_cnt_o)) conflict_cnt_o <= conflict_cnt_o + 1'b1;
      // RAM must answer exactly the non-error accesses, nothing more.
      if (mem_rvalid_i != (head.vld & ~head.err)) protocol_err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ibex_mem_arbiter.sv
// Scoreboard bench: DUT 0 (latency 1, round-robin), DUT 1 (latency 2, data priority),
// each with its own RAM model; a monitor pops expected responses on every rvalid.
module tb_ibex_mem_arbiter;

  typedef struct {
    bit          port;   // 1 = data
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ireq [2], igt [2], irv [2], ierr [2];
  logic [31:0] iaddr [2], irdata [2];
  logic        dreq [2], dgnt [2], drv [2], dwe [2], derr [2];
  logic [3:0]  dbe [2];
  logic [31:0] daddr [2], dwdata [2], drdata [2];
  logic        mreq [2], mwr [2], mrv [2];
  logic [3:0]  mbe [2];
  logic [13:0] maddr [2];
  logic [31:0] mwdata [2], mrdata [2];
  logic [15:0] ccnt [2];
  logic        perr [2];

  int   checks = 0;
  int   errors = 0;
  exp_t q0 [$];
  exp_t q1 [$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 2;
    logic [31:0] mem [16384];
    logic [L:1]  rv_p;
    logic [31:0] rd_p [L:1];
    logic [31:0] w;

    ibex_mem_arbiter #(.MemLatency(L), .DataPrio(g)) u_dut (
      .clk_i(clk), .rst_i(rst),
      .instr_req_i(ireq[g]), .instr_gnt_o(igt[g]), .instr_rvalid_o(irv[g]),
      .instr_addr_i(iaddr[g]), .instr_rdata_o(irdata[g]), .instr_err_o(ierr[g]),
      .data_req_i(dreq[g]), .data_gnt_o(dgnt[g]), .data_rvalid_o(drv[g]),
      .data_we_i(dwe[g]), .data_be_i(dbe[g]), .data_addr_i(daddr[g]),
      .data_wdata_i(dwdata[g]), .data_rdata_o(drdata[g]), .data_err_o(derr[g]),
      .mem_req_o(mreq[g]), .mem_write_o(mwr[g]), .mem_be_o(mbe[g]),
      .mem_addr_o(maddr[g]), .mem_wdata_o(mwdata[g]),
      .mem_rvalid_i(mrv[g]), .mem_rdata_i(mrdata[g]),
      .conflict_cnt_o(ccnt[g]), .protocol_err_o(perr[g])
    );

    // RAM model: contents are (re)loaded while reset is high
    always @(posedge clk) begin
      if (rst) begin
        mem[14'h0000] = 32'h0BAD_0000;
        mem[14'h0002] = 32'hCAFE_0002;
        mem[14'h0020] = 32'h0000_0013;
        mem[14'h0021] = 32'h1111_2222;
        mem[14'h0400] = 32'h0000_0000;
        mem[14'h3FFF] = 32'h7E7E_7E7E;
        rv_p <= '0;
      end else begin
        for (int i = L; i > 1; i--) begin
          rv_p[i] <= rv_p[i-1];
          rd_p[i] <= rd_p[i-1];
        end
        rv_p[1] <= mreq[g];
        rd_p[1] <= (mreq[g] && !mwr[g]) ? mem[maddr[g]] : 32'h0;
        if (mreq[g] && mwr[g]) begin
          w = mem[maddr[g]];
          for (int b = 0; b < 4; b++) if (mbe[g][b]) w[8*b +: 8] = mwdata[g][8*b +: 8];
          mem[maddr[g]] = w;
        end
      end
    end
    assign mrv[g]    = rv_p[L];
    assign mrdata[g] = rd_p[L];
  end

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic push(input int g, input bit port, input logic [31:0] rd, input bit err);
    exp_t e;
    e.port = port; e.rdata = rd; e.err = err;
    if (g == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Monitor: every presented response must match the oldest expectation
  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      exp_t e;
      bit   have;
      if (irv[g] || drv[g]) begin
        have = (g == 0) ? (q0.size() != 0) : (q1.size() != 0);
        chk($sformatf("d%0d_rsp_expected", g), {31'd0, have}, 32'd1);
        chk($sformatf("d%0d_one_rvalid", g), {31'd0, irv[g] & drv[g]}, 32'd0);
        if (have) begin
          e = (g == 0) ? q0.pop_front() : q1.pop_front();
          chk($sformatf("d%0d_rsp_port", g), {31'd0, drv[g]}, {31'd0, e.port});
          chk($sformatf("d%0d_rsp_rdata", g), drv[g] ? drdata[g] : irdata[g], e.rdata);
          chk($sformatf("d%0d_rsp_err", g), {31'd0, drv[g] ? derr[g] : ierr[g]}, {31'd0, e.err});
          chk($sformatf("d%0d_idle_rdata", g), drv[g] ? irdata[g] : drdata[g], 32'h0);
          chk($sformatf("d%0d_idle_err", g), {31'd0, drv[g] ? ierr[g] : derr[g]}, 32'd0);
        end
      end
    end
  end

  initial begin
    for (int g = 0; g < 2; g++) begin
      ireq[g] = 1'b1; iaddr[g] = 32'h80;
      dreq[g] = 1'b1; daddr[g] = 32'h84; dwe[g] = 1'b0; dbe[g] = 4'hF; dwdata[g] = 32'h0;
    end
    // requests held during reset must be ignored
    step();
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst_igt%0d", g), {31'd0, igt[g]}, 32'd0);
      chk($sformatf("rst_dgnt%0d", g), {31'd0, dgnt[g]}, 32'd0);
      chk($sformatf("rst_mreq%0d", g), {31'd0, mreq[g]}, 32'd0);
      chk($sformatf("rst_ccnt%0d", g), {16'd0, ccnt[g]}, 32'd0);
      chk($sformatf("rst_perr%0d", g), {31'd0, perr[g]}, 32'd0);
    end
    step();
    for (int g = 0; g < 2; g++) begin ireq[g] = 1'b0; dreq[g] = 1'b0; end
    rst = 1'b0;
    step();

    // instr-only fetch
    ireq[0] = 1'b1; iaddr[0] = 32'h80; push(0, 0, 32'h13, 0);
    @(negedge clk);
    chk("t1_igt", {31'd0, igt[0]}, 32'd1);
    chk("t1_dgnt", {31'd0, dgnt[0]}, 32'd0);
    chk("t1_mreq", {31'd0, mreq[0]}, 32'd1);
    chk("t1_maddr", {18'd0, maddr[0]}, 32'h20);
    chk("t1_mbe", {28'd0, mbe[0]}, 32'hF);
    step(); ireq[0] = 1'b0; step(); step();

    // round-robin conflict: instr, data, instr, data
    ireq[0] = 1'b1; dreq[0] = 1'b1; iaddr[0] = 32'h80; daddr[0] = 32'h84;
    for (int k = 0; k < 4; k++) begin
      bit ei;
      ei = (k % 2 == 0);
      push(0, !ei, ei ? 32'h13 : 32'h1111_2222, 0);
      @(negedge clk);
      chk($sformatf("t2_igt_%0d", k), {31'd0, igt[0]}, {31'd0, ei});
      chk($sformatf("t2_dgnt_%0d", k), {31'd0, dgnt[0]}, {31'd0, !ei});
      step();
    end
    ireq[0] = 1'b0; dreq[0] = 1'b0;
    @(negedge clk);
    chk("t2_ccnt", {16'd0, ccnt[0]}, 32'd4);
    step(); step();

    // data priority on DUT 1
    ireq[1] = 1'b1; dreq[1] = 1'b1; iaddr[1] = 32'h0; daddr[1] = 32'h8;
    for (int k = 0; k < 3; k++) begin
      push(1, 1, 32'hCAFE_0002, 0);
      @(negedge clk);
      chk($sformatf("t3_dgnt_%0d", k), {31'd0, dgnt[1]}, 32'd1);
      chk($sformatf("t3_igt_%0d", k), {31'd0, igt[1]}, 32'd0);
      step();
    end
    ireq[1] = 1'b0; dreq[1] = 1'b0;
    @(negedge clk);
    chk("t3_ccnt1", {16'd0, ccnt[1]}, 32'd3);
    chk("t3_ccnt0", {16'd0, ccnt[0]}, 32'd4);
    step(); step(); step();

    // partial write then read back
    dreq[0] = 1'b1; dwe[0] = 1'b1; dbe[0] = 4'b0011; daddr[0] = 32'h1000; dwdata[0] = 32'hDEAD_BEEF;
    push(0, 1, 32'h0, 0);
    @(negedge clk);
    chk("t4_wgnt", {31'd0, dgnt[0]}, 32'd1);
    chk("t4_mwr", {31'd0, mwr[0]}, 32'd1);
    chk("t4_mbe", {28'd0, mbe[0]}, 32'h3);
    chk("t4_maddr", {18'd0, maddr[0]}, 32'h400);
    chk("t4_mwdata", mwdata[0], 32'hDEAD_BEEF);
    step();
    dwe[0] = 1'b0; dbe[0] = 4'hF; dwdata[0] = 32'h0;
    push(0, 1, 32'h0000_BEEF, 0);
    @(negedge clk);
    chk("t4_rd_mwr", {31'd0, mwr[0]}, 32'd0);
    step(); dreq[0] = 1'b0; step(); step();

    // out of range, then the last in-range word
    dreq[0] = 1'b1; daddr[0] = 32'h0001_0000; push(0, 1, 32'h0, 1);
    @(negedge clk);
    chk("t5_oor_gnt", {31'd0, dgnt[0]}, 32'd1);
    chk("t5_oor_mreq", {31'd0, mreq[0]}, 32'd0);
    chk("t5_oor_maddr", {18'd0, maddr[0]}, 32'h0);
    step();
    daddr[0] = 32'h0000_FFFC; push(0, 1, 32'h7E7E_7E7E, 0);
    @(negedge clk);
    chk("t5_top_mreq", {31'd0, mreq[0]}, 32'd1);
    chk("t5_top_maddr", {18'd0, maddr[0]}, 32'h3FFF);
    step(); dreq[0] = 1'b0;
    ireq[1] = 1'b1; iaddr[1] = 32'hFFFF_FFFC; push(1, 0, 32'h0, 1);
    @(negedge clk);
    chk("t5_ioor_gnt", {31'd0, igt[1]}, 32'd1);
    chk("t5_ioor_mreq", {31'd0, mreq[1]}, 32'd0);
    step(); ireq[1] = 1'b0; step(); step(); step();
    @(negedge clk);
    chk("t5_perr0", {31'd0, perr[0]}, 32'd0);
    chk("t5_perr1", {31'd0, perr[1]}, 32'd0);
    step();

    // reset one cycle after a grant on the latency-2 DUT: response must vanish
    ireq[1] = 1'b1; iaddr[1] = 32'h0;
    @(negedge clk);
    chk("t6_igt1", {31'd0, igt[1]}, 32'd1);
    step();
    ireq[1] = 1'b0; rst = 1'b1;
    step(); step();
    rst = 1'b0;
    repeat (4) step();
    @(negedge clk);
    chk("t6_ccnt0", {16'd0, ccnt[0]}, 32'd0);
    chk("t6_ccnt1", {16'd0, ccnt[1]}, 32'd0);
    chk("t6_perr1", {31'd0, perr[1]}, 32'd0);
    step();
    ireq[0] = 1'b1; dreq[0] = 1'b1; iaddr[0] = 32'h80; daddr[0] = 32'h84;
    push(0, 0, 32'h13, 0);
    @(negedge clk);
    chk("t6_first_igt", {31'd0, igt[0]}, 32'd1);
    chk("t6_first_dgnt", {31'd0, dgnt[0]}, 32'd0);
    step();
    ireq[0] = 1'b0; dreq[0] = 1'b0;
    @(negedge clk);
    chk("t6_ccnt_after", {16'd0, ccnt[0]}, 32'd1);
    step(); step(); step();

    @(negedge clk);
    chk("drain_q0", q0.size(), 32'd0);
    chk("drain_q1", q1.size(), 32'd0);
    chk("end_perr0", {31'd0, perr[0]}, 32'd0);
    chk("end_perr1", {31'd0, perr[1]}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_mem_arbiter.md
Name: ibex_mem_arbiter

Overview:
Shares the single-port instruction/data RAM between the Ibex instruction-fetch and data (LSU) ports. Each cycle it arbitrates between the two requesters and translates byte addresses to RAM word indices. It tracks in-flight responses so each rvalid/rdata returns to the port that issued it, and answers out-of-range accesses with an error response. It sits between the core's instr_*/data_* ports and the RAM's mem_* ports in the testbench/BFM wiring.

Parameters:
MemDepth, 16384, RAM depth in 32-bit words
MemAw, $clog2(MemDepth), RAM word-index width (derived; do not override)
BaseAddr, 32'h00000000, byte address mapped to RAM word 0
MemLatency, 1, cycles from mem_req to RAM read data/rvalid (1..4)
DataPrio, 0, 1 = data port always wins conflicts; 0 = round-robin
CntWidth, 16, width of the conflict counter

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
instr_req_i  in  1  fetch request
instr_gnt_o  out  1  fetch grant
instr_rvalid_o  out  1  fetch response valid
instr_addr_i  in  32  fetch byte address
instr_rdata_o  out  32  fetch read data
instr_err_o  out  1  fetch error, qualified by instr_rvalid_o
data_req_i  in  1  LSU request
data_gnt_o  out  1  LSU grant
data_rvalid_o  out  1  LSU response valid, for reads and writes
data_we_i  in  1  LSU write enable
data_be_i  in  4  LSU byte enables
data_addr_i  in  32  LSU byte address
data_wdata_i  in  32  LSU write data
data_rdata_o  out  32  LSU read data
data_err_o  out  1  LSU error, qualified by data_rvalid_o
mem_req_o  out  1  RAM request
mem_write_o  out  1  RAM write enable
mem_be_o  out  4  RAM byte enables
mem_addr_o  out  MemAw  RAM word index
mem_wdata_o  out  32  RAM write data
mem_rvalid_i  in  1  RAM response valid
mem_rdata_i  in  32  RAM read data
conflict_cnt_o  out  CntWidth  cycles with both requests high, saturating
protocol_err_o  out  1  sticky: mem_rvalid_i disagreed with the internal tracker

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i).
- While rst_i is high:
  - gnt, mem_req_o, rvalid and err outputs are forced to 0.
  - The response pipeline is flushed.
  - last_winner resets to DATA.
  - conflict_cnt_o resets to 0 and protocol_err_o resets to 0.
  - Requests present during reset are not granted and are not remembered.
- Grants are combinational in the request cycle, with at most one grant per cycle:
  - Only one port requesting: that port wins.
  - Both requesting, DataPrio=1: data wins.
  - Both requesting, DataPrio=0: the port that is not last_winner wins.
  - last_winner updates only on cycles where both ports request.
- Winner is in range when BaseAddr <= addr < BaseAddr + 4*MemDepth:
  - mem_req_o=1.
  - mem_addr_o = (addr - BaseAddr)[MemAw+1:2]; addr[1:0] is ignored.
  - mem_write_o, mem_be_o and mem_wdata_o come from the winner; the instr port drives we=0, be=4'hF, wdata=0.
- Winner is out of range: grant is still given, mem_req_o=0, and the response is marked err.
- When mem_req_o=0, the other mem_* outputs are don't-care; drive them to 0.
- Response tracker: shift register, MemLatency stages deep, entries {valid, owner, err}. A grant pushes one entry each cycle; there is no backpressure.
- Each stage-MemLatency output produces exactly one cycle of rvalid to its owner, exactly MemLatency cycles after the grant:
  - rdata = mem_rdata_i, or 32'h0 if err.
  - err output = entry err.
  - Write responses also assert rvalid.
- The non-owner port's rvalid and err are 0. Its rdata is 0.
- Back-to-back grants, including alternating owners, are fully pipelined at one access per cycle.
- protocol_err_o sets when the output entry is valid, not err, and mem_rvalid_i=0. It also sets when mem_rvalid_i=1 with no valid non-err entry. It stays set until reset.
- conflict_cnt_o increments on every cycle with instr_req_i & data_req_i and saturates at all-ones.
- Reset asserted mid-transaction: in-flight responses are dropped and no rvalid is produced after reset deasserts.

Test Plan:
- Instr-only: instr_req at addr 0x80 with RAM[0x20]=0x00000013 -> gnt same cycle, mem_addr=0x20, instr_rvalid one cycle later with rdata 0x00000013, data_rvalid stays 0.
- Conflict, DataPrio=0: both request for 4 cycles -> grants in order instr, data, instr, data; conflict_cnt_o=4; responses return in the same order on the matching port.
- DataPrio=1: both request for 3 cycles -> data granted every cycle, instr_gnt=0, conflict_cnt_o=3.
- Data write then read: write 0xDEADBEEF, be=4'b0011 at 0x1000, then read 0x1000 with prior contents 0 -> write rvalid, then read rdata=0x0000BEEF.
- Out of range: data read at 0x00010000 with MemDepth 16384 -> gnt=1, mem_req=0, data_rvalid with err=1 and rdata=0; protocol_err_o stays 0.
- Reset mid-flight: grant at cycle N, rst_i high at N+1 with MemLatency=2 -> no rvalid after reset, conflict_cnt_o=0, first conflict after reset grants instr.
